// File: rtl/bram_stream_reader_pkg.sv
// Shared defaults and FSM state encoding for the BRAM stream reader.
package bram_stream_reader_pkg;

    localparam int DWIDTH_DEF   = 8;
    localparam int AWIDTH_DEF   = 7;
    localparam int MEM_SIZE_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO that catches BRAM read data so the stream can stall without losing words.
module bram_rd_skid
    import bram_stream_reader_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head_data,
    output logic [1:0]        count,
    output logic              empty,
    output logic              full
);

    logic [DWIDTH-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == 2'd0);
    assign full      = (count == 2'd2);

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive BRAM words and streams them out in address order,
// issuing reads only when the skid buffer is guaranteed to have room for the result.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    input  logic [AWIDTH-1:0] i_base_addr,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    input  logic [DWIDTH-1:0] q0,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_idle,
    output logic              o_read,
    output logic              o_done
);

    localparam logic [AWIDTH:0] MEM_LIMIT = (AWIDTH+1)'(MEM_SIZE);

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] num_q;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH-1:0] issued;
    logic [AWIDTH-1:0] popped;
    logic              inflight;
    logic              pop;
    logic              start;
    logic [1:0]        buf_cnt;
    logic              buf_empty;
    logic              buf_full;
    logic [2:0]        occupancy;
    logic [AWIDTH:0]   addr_sum;
    logic [AWIDTH:0]   popped_sum;

    assign we0     = 1'b0;
    assign o_valid = ~buf_empty;
    assign pop     = o_valid & i_ready;
    assign start   = (state == IDLE) & i_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy counts words already buffered plus the one still coming out of the BRAM,
    // less the one leaving this cycle; a new read is only allowed if it will fit.
    always_comb begin
        state_next = state;
        o_idle     = 1'b0;
        o_read     = 1'b0;
        o_done     = 1'b0;
        ce0        = 1'b0;
        addr0      = '0;
        occupancy  = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        addr_sum   = {1'b0, base_q} + {1'b0, issued};
        popped_sum = {1'b0, popped} + {{AWIDTH{1'b0}}, pop};
        case (state)
            IDLE: begin
                o_idle = 1'b1;
                if (i_run) begin
                    state_next = READ;
                end
            end
            READ: begin
                o_read = 1'b1;
                if ((issued < num_q) && (occupancy < 3'd2)) begin
                    ce0   = 1'b1;
                    addr0 = AWIDTH'((addr_sum >= MEM_LIMIT) ? (addr_sum - MEM_LIMIT) : addr_sum);
                end
                if (popped_sum == {1'b0, num_q}) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_q    <= '0;
            base_q   <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= ce0;
            if (start) begin
                num_q  <= i_num_cnt;
                base_q <= i_base_addr;
                issued <= '0;
                popped <= '0;
            end else begin
                if (ce0) begin
                    issued <= issued + AWIDTH'(1);
                end
                if (pop) begin
                    popped <= popped + AWIDTH'(1);
                end
            end
        end
    end

    bram_rd_skid #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (inflight),
        .push_data(q0),
        .pop      (pop),
        .head_data(o_data),
        .count    (buf_cnt),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    // Issue gating must make it impossible for returning data to find the buffer full.
    skid_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(inflight && buf_full && !pop));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a behavioural 128x8 BRAM with mem[a]=a^A5.
module tb_bram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int MS = 128;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_run;
    logic [AW-1:0] i_num_cnt;
    logic [AW-1:0] i_base_addr;
    logic [AW-1:0] addr0;
    logic          ce0;
    logic          we0;
    logic [DW-1:0] q0;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_idle;
    logic          o_read;
    logic          o_done;

    logic [DW-1:0] mem [MS];
    logic [DW-1:0] data_q [$];
    logic [AW-1:0] addr_q [$];

    int checks      = 0;
    int errors      = 0;
    int cur_cyc     = 0;
    int first_valid = -1;
    int done_cyc    = -1;
    int done_total  = 0;
    int issue_total = 0;
    int outstanding = 0;

    always #5 clk = ~clk;

    bram_stream_reader #(
        .DWIDTH  (DW),
        .AWIDTH  (AW),
        .MEM_SIZE(MS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (i_run),
        .i_num_cnt  (i_num_cnt),
        .i_base_addr(i_base_addr),
        .addr0      (addr0),
        .ce0        (ce0),
        .we0        (we0),
        .q0         (q0),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_idle     (o_idle),
        .o_read     (o_read),
        .o_done     (o_done)
    );

    initial begin
        for (int a = 0; a < MS; a++) begin
            mem[a] = DW'(a) ^ 8'hA5;
        end
    end

    always @(posedge clk) begin
        if (ce0) begin
            q0 <= mem[addr0];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every presented word and every issued read against the queues.
    always @(negedge clk) begin
        logic popv;
        if (!reset_n) begin
            outstanding = 0;
        end else begin
            popv = o_valid && i_ready;
            if (o_valid) begin
                if (first_valid < 0) first_valid = cur_cyc;
                if (data_q.size() == 0) begin
                    check_output("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check_output("o_data", 32'(o_data), 32'(data_q[0]));
                    if (popv) void'(data_q.pop_front());
                end
            end
            if (ce0) begin
                issue_total++;
                check_output("ce0_room", 32'((outstanding - (popv ? 1 : 0)) <= 1), 32'd1);
                if (addr_q.size() == 0) begin
                    check_output("unexpected_ce0", 32'd1, 32'd0);
                end else begin
                    check_output("addr0", 32'(addr0), 32'(addr_q.pop_front()));
                end
            end
            if (o_done) begin
                done_total++;
                done_cyc = cur_cyc;
            end
            outstanding = outstanding + (ce0 ? 1 : 0) - (popv ? 1 : 0);
        end
    end

    // One run: queue expectations, pulse i_run, drive the ready pattern until o_done.
    task automatic apply_stimulus(input int base, input int num, input logic [15:0] pat,
                                  input int rerun_at, input int reset_at);
        int done_before;
        int issue_before;
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < num; i++) begin
            addr_q.push_back(AW'((base + i) % MS));
            data_q.push_back(DW'((base + i) % MS) ^ 8'hA5);
        end
        done_before  = done_total;
        issue_before = issue_total;
        first_valid  = -1;
        done_cyc     = -1;
        cur_cyc      = 0;
        i_base_addr  = AW'(base);
        i_num_cnt    = AW'(num);
        i_run        = 1'b1;
        @(posedge clk);
        #1;
        i_run   = 1'b0;
        cur_cyc = 1;
        i_ready = pat[1];
        while (done_total == done_before && cur_cyc < 300 && !aborted) begin
            @(posedge clk);
            #1;
            cur_cyc++;
            i_ready = pat[cur_cyc % 16];
            i_run   = (cur_cyc == rerun_at);
            if (cur_cyc == rerun_at) begin
                i_base_addr = 7'd50;
                i_num_cnt   = 7'd9;
            end
            if (cur_cyc == reset_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_output("rst_o_valid", 32'(o_valid), 32'd0);
                check_output("rst_ce0", 32'(ce0), 32'd0);
                check_output("rst_o_idle", 32'(o_idle), 32'd1);
                check_output("rst_o_read", 32'(o_read), 32'd0);
                aborted = 1'b1;
            end
        end
        i_run = 1'b0;
        if (aborted) begin
            repeat (2) @(posedge clk);
            data_q.delete();
            addr_q.delete();
            #1;
            reset_n = 1'b1;
            i_ready = 1'b1;
            return;
        end
        if (done_total == done_before) begin
            check_output("done_timeout", 32'd0, 32'd1);
        end else if (num == 0) begin
            check_output("done_cycle", 32'(done_cyc), 32'd2);
        end else if (pat == 16'hFFFF) begin
            check_output("first_valid_cycle", 32'(first_valid), 32'd3);
            check_output("done_cycle", 32'(done_cyc), 32'(num + 3));
        end
        i_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            cur_cyc++;
        end
        check_output("done_pulses", 32'(done_total - done_before), 32'd1);
        check_output("words_left", 32'(data_q.size()), 32'd0);
        check_output("ce0_count", 32'(issue_total - issue_before), 32'(num));
        check_output("idle_after", 32'(o_idle), 32'd1);
        if (num == 0) begin
            check_output("valid_seen", 32'(first_valid), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        reset_n     = 1'b1;
        i_run       = 1'b0;
        i_num_cnt   = '0;
        i_base_addr = '0;
        i_ready     = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check_output("reset_o_idle", 32'(o_idle), 32'd1);
        check_output("reset_ce0", 32'(ce0), 32'd0);
        check_output("reset_addr0", 32'(addr0), 32'd0);
        check_output("reset_o_valid", 32'(o_valid), 32'd0);
        check_output("reset_o_data", 32'(o_data), 32'd0);
        check_output("reset_o_read", 32'(o_read), 32'd0);
        check_output("reset_o_done", 32'(o_done), 32'd0);
        check_output("reset_we0", 32'(we0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] basic two-word read");
        apply_stimulus(0, 2, 16'hFFFF, -1, -1);
        $display("[TB] address wrap");
        apply_stimulus(126, 4, 16'hFFFF, -1, -1);
        $display("[TB] backpressure");
        apply_stimulus(0, 5, 16'h9A53, -1, -1);
        $display("[TB] zero-length run");
        apply_stimulus(5, 0, 16'hFFFF, -1, -1);
        $display("[TB] reset mid-transfer, then new run");
        apply_stimulus(0, 5, 16'h9A53, -1, 5);
        apply_stimulus(10, 3, 16'hFFFF, -1, -1);
        $display("[TB] i_run during READ");
        apply_stimulus(20, 6, 16'hFFFF, 3, -1);
        $display("[TB] long wrapped run with backpressure");
        apply_stimulus(120, 12, 16'h3C3C, -1, -1);
        check_output("final_we0", 32'(we0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
